// File: rtl/register_write_sequencer.sv
// register_write_sequencer
//   Upstream feeder for a bank of write-once 16-bit config registers.
//   Host requests are buffered in a small FIFO. Each request is checked
//   against the address range and the shadow lock. If it is accepted, it is
//   played out as setup / one-cycle strobe / hold on the one-hot write bus.
//
// Ports
//   Clk          clock, everything on posedge
//   ip_reset     synchronous reset, active-high
//   req_valid    host request valid
//   req_ready    FIFO can accept (not full)
//   req_addr     target register index
//   req_data     write data, bit0=1 locks the target
//   write        one-hot write strobe to the register bank
//   wr_data      data presented to the register bank
//   busy         sequencer not idle, or FIFO not empty
//   err_valid    one-cycle reject pulse
//   err_code     01 = target locked, 10 = address out of range
//   lock_status  shadow write-once lock per register
//   err_count    (REG_SEQ_ERR_COUNT_EN only) saturating reject counter
//
// Optional feature: define REG_SEQ_ERR_COUNT_EN to add the err_count output.
//
// state  | meaning
// IDLE   | waiting for a buffered request; pops the FIFO head
// CHECK  | range/lock check on the popped request
// SETUP  | wr_data stable, write low
// STROBE | one-hot write high for one cycle, lock shadow updated
// HOLD   | wr_data held for HOLD_CYCLES cycles
module register_write_sequencer #(
  parameter int NUM_REGS    = 4,
  parameter int ADDR_W      = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 1
) (
  input  logic                Clk,
  input  logic                ip_reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [15:0]         req_data,
  output logic [NUM_REGS-1:0] write,
  output logic [15:0]         wr_data,
  output logic                busy,
  output logic                err_valid,
  output logic [1:0]          err_code,
`ifdef REG_SEQ_ERR_COUNT_EN
  output logic [7:0]          err_count,
`endif
  output logic [NUM_REGS-1:0] lock_status
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int HC_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    SETUP,
    STROBE,
    HOLD
  } state_t;

  state_t state;

  logic [ADDR_W+15:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;

  logic [ADDR_W-1:0]   cur_addr;
  logic [15:0]         cur_data;
  logic [HC_W-1:0]     hold_cnt;
  logic [NUM_REGS-1:0] addr_onehot;
  logic                addr_valid;
  logic                locked;

  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign push       = req_valid && !fifo_full;
  assign pop        = (state == IDLE) && !fifo_empty;
  assign req_ready  = !fifo_full;
  assign busy       = (state != IDLE) || !fifo_empty;

  // Decode through a compare loop so an out-of-range address never indexes the lock vector.
  always_comb begin
    addr_onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      addr_onehot[i] = (int'(cur_addr) == i);
    end
  end

  assign addr_valid = (int'(cur_addr) < NUM_REGS);
  assign locked     = |(lock_status & addr_onehot);

  // Storage needs no reset: only entries below count are ever read.
  always_ff @(posedge Clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {req_addr, req_data};
    end
  end

  always_ff @(posedge Clk) begin
    if (ip_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (ip_reset) begin
      state       <= IDLE;
      cur_addr    <= '0;
      cur_data    <= '0;
      hold_cnt    <= '0;
      write       <= '0;
      wr_data     <= 16'h0000;
      err_valid   <= 1'b0;
      err_code    <= 2'b00;
      lock_status <= '0;
    end else begin
      err_valid <= 1'b0;
      write     <= '0;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            {cur_addr, cur_data} <= fifo_mem[rd_ptr];
            state                <= CHECK;
          end
        end
        CHECK: begin
          if (!addr_valid) begin
            err_valid <= 1'b1;
            err_code  <= 2'b10;
            state     <= IDLE;
          end else if (locked) begin
            err_valid <= 1'b1;
            err_code  <= 2'b01;
            state     <= IDLE;
          end else begin
            wr_data <= cur_data;
            state   <= SETUP;
          end
        end
        SETUP: begin
          // write is registered, so it is high during the STROBE cycle.
          write <= addr_onehot;
          state <= STROBE;
        end
        STROBE: begin
          lock_status <= lock_status | (addr_onehot & {NUM_REGS{cur_data[0]}});
          hold_cnt    <= HC_W'(HOLD_CYCLES - 1);
          state       <= HOLD;
        end
        HOLD: begin
          if (hold_cnt == '0) begin
            state <= IDLE;
          end else begin
            hold_cnt <= hold_cnt - HC_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef REG_SEQ_ERR_COUNT_EN
  always_ff @(posedge Clk) begin
    if (ip_reset) begin
      err_count <= 8'h00;
    end else if (err_valid && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_register_write_sequencer.sv
module tb_register_write_sequencer;
  localparam int NREGS = 4;
  localparam int AW    = 4;
  localparam int DEPTH = 4;
  localparam int HOLD  = 8;

  logic             Clk = 1'b0;
  logic             ip_reset = 1'b1;
  logic             req_valid = 1'b0;
  logic [AW-1:0]    req_addr = '0;
  logic [15:0]      req_data = '0;
  logic             req_ready;
  logic [NREGS-1:0] write;
  logic [15:0]      wr_data;
  logic             busy;
  logic             err_valid;
  logic [1:0]       err_code;
  logic [NREGS-1:0] lock_status;
`ifdef REG_SEQ_ERR_COUNT_EN
  logic [7:0]       err_count;
`endif

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int acc_cyc = 0;
  bit chk_en = 1'b0;

  always #5 Clk = ~Clk;

  register_write_sequencer #(
    .NUM_REGS(NREGS), .ADDR_W(AW), .FIFO_DEPTH(DEPTH), .HOLD_CYCLES(HOLD)
  ) dut (
    .Clk(Clk), .ip_reset(ip_reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .write(write), .wr_data(wr_data),
    .busy(busy), .err_valid(err_valid), .err_code(err_code),
`ifdef REG_SEQ_ERR_COUNT_EN
    .err_count(err_count),
`endif
    .lock_status(lock_status)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level model: each popped request schedules its visible effects
  // at fixed offsets from the pop edge; the engine is free again afterwards.
  typedef struct packed { logic [AW-1:0] a; logic [15:0] d; } req_t;
  req_t q[$];
  int next_pop, err_cyc, wd_cyc, wr_cyc, lk_cyc;
  logic [NREGS-1:0] sched_onehot, sched_lock, m_write, m_lock;
  logic [15:0] sched_wd, m_wd;
  logic [1:0] sched_code, m_code;
  logic m_err, m_busy, m_ready;
  int m_errcnt;

  always @(posedge Clk) begin
    bit can_push;
    req_t r;
    cyc++;
    if (ip_reset) begin
      q.delete();
      next_pop = 0; err_cyc = -1; wd_cyc = -1; wr_cyc = -1; lk_cyc = -1;
      m_write = '0; m_lock = '0; m_wd = '0; m_err = 1'b0; m_code = 2'b00; m_errcnt = 0;
    end else begin
      can_push = req_valid && (q.size() < DEPTH);
      if (m_err && m_errcnt < 255) m_errcnt++;
      m_write = (cyc == wr_cyc) ? sched_onehot : '0;
      if (cyc == wd_cyc) m_wd = sched_wd;
      if (cyc == lk_cyc) m_lock = m_lock | sched_lock;
      m_err = (cyc == err_cyc);
      if (m_err) m_code = sched_code;
      if (cyc >= next_pop && q.size() > 0) begin
        r = q.pop_front();
        if (int'(r.a) >= NREGS) begin
          err_cyc = cyc + 1; sched_code = 2'b10; next_pop = cyc + 2;
        end else if (m_lock[r.a]) begin
          err_cyc = cyc + 1; sched_code = 2'b01; next_pop = cyc + 2;
        end else begin
          wd_cyc = cyc + 1; sched_wd = r.d;
          wr_cyc = cyc + 2; sched_onehot = NREGS'(1) << r.a;
          lk_cyc = cyc + 3; sched_lock = r.d[0] ? (NREGS'(1) << r.a) : '0;
          next_pop = cyc + 4 + HOLD;
        end
      end
      if (can_push) q.push_back({req_addr, req_data});
    end
    m_ready = (q.size() < DEPTH);
    m_busy  = (cyc < next_pop - 1) || (q.size() > 0);
  end

  logic [1:0] last_code;
  int         strobe_cyc[$];
  logic [3:0] strobe_w[$];

  always @(negedge Clk) begin
    if (chk_en) begin
      chk("write", 32'(write), 32'(m_write));
      chk("wr_data", 32'(wr_data), 32'(m_wd));
      chk("lock_status", 32'(lock_status), 32'(m_lock));
      chk("err_valid", 32'(err_valid), 32'(m_err));
      if (m_err) chk("err_code", 32'(err_code), 32'(m_code));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("req_ready", 32'(req_ready), 32'(m_ready));
`ifdef REG_SEQ_ERR_COUNT_EN
      chk("err_count", 32'(err_count), 32'(m_errcnt));
`endif
      if (err_valid) last_code = err_code;
      if (write != '0) begin
        strobe_cyc.push_back(cyc);
        strobe_w.push_back(write);
      end
    end
  end

  // Called at a negedge; returns at the negedge of the accepting cycle.
  task automatic push(input logic [AW-1:0] a, input logic [15:0] d);
    int g = 0;
    req_valid = 1'b1; req_addr = a; req_data = d;
    while (!req_ready && g < 400) begin
      @(negedge Clk);
      g++;
    end
    chk("push_ready", 32'(req_ready), 32'd1);
    acc_cyc = cyc + 1;
    @(negedge Clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    @(negedge Clk);
    while (busy && g < 500) begin
      @(negedge Clk);
      g++;
    end
    chk("idle_reached", 32'(busy), 32'd0);
    @(negedge Clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_w[5];
    int g;
    exp_w[0] = 4'b0001; exp_w[1] = 4'b0010; exp_w[2] = 4'b1000;
    exp_w[3] = 4'b0001; exp_w[4] = 4'b0010;
    last_code = 2'b00;

    repeat (3) @(negedge Clk);
    ip_reset = 1'b0;
    chk_en = 1'b1;
    @(negedge Clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_write", 32'(write), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_lock", 32'(lock_status), 32'd0);
    chk("rst_err_valid", 32'(err_valid), 32'd0);

    // basic write, strobe three cycles after accept
    push(4'd1, 16'h1234);
    while (cyc < acc_cyc + 2) @(negedge Clk);
    chk("t1_setup_write", 32'(write), 32'd0);
    chk("t1_setup_data", 32'(wr_data), 32'h1234);
    @(negedge Clk);
    chk("t1_strobe", 32'(write), 32'b0010);
    @(negedge Clk);
    chk("t1_after_strobe", 32'(write), 32'd0);
    chk("t1_lock", 32'(lock_status), 32'd0);
    wait_idle();

    // lock then rejected rewrite
    push(4'd2, 16'h00A1);
    push(4'd2, 16'h5550);
    wait_idle();
    chk("t2_lock", 32'(lock_status), 32'b0100);
    chk("t2_code", 32'(last_code), 32'b01);
    chk("t2_wr_data", 32'(wr_data), 32'h00A1);

    // out-of-range address
    last_code = 2'b00;
    strobe_cyc.delete(); strobe_w.delete();
    push(4'd9, 16'hBEEF);
    wait_idle();
    chk("t3_code", 32'(last_code), 32'b10);
    chk("t3_wr_data", 32'(wr_data), 32'h00A1);
    chk("t3_no_strobe", 32'(strobe_cyc.size()), 32'd0);

    // fill the FIFO behind a long hold
    strobe_cyc.delete(); strobe_w.delete();
    push(4'd0, 16'h1110);
    push(4'd1, 16'h2220);
    push(4'd3, 16'h3330);
    push(4'd0, 16'h4440);
    push(4'd1, 16'h5550);
    chk("t4_full", 32'(req_ready), 32'd0);
    wait_idle();
    chk("t4_strobes", 32'(strobe_cyc.size()), 32'd5);
    if (strobe_cyc.size() == 5) begin
      for (int i = 0; i < 5; i++) chk("t4_order", 32'(strobe_w[i]), 32'(exp_w[i]));
      for (int i = 1; i < 5; i++) chk("t4_spacing", 32'(strobe_cyc[i] - strobe_cyc[i-1]), 32'd12);
    end

    // reset in the middle of a strobe with two requests queued
    push(4'd0, 16'h0001);
    push(4'd1, 16'h0002);
    push(4'd3, 16'h0003);
    g = 0;
    while (write == '0 && g < 20) begin
      @(negedge Clk);
      g++;
    end
    chk("t5_in_strobe", 32'(write), 32'b0001);
    ip_reset = 1'b1;
    @(negedge Clk);
    chk("t5_write", 32'(write), 32'd0);
    chk("t5_lock", 32'(lock_status), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_ready", 32'(req_ready), 32'd1);
    chk("t5_wr_data", 32'(wr_data), 32'd0);
    ip_reset = 1'b0;
    repeat (4) @(negedge Clk);
    chk("t5_discarded", 32'(busy), 32'd0);
    chk("t5_no_strobe", 32'(write), 32'd0);

`ifdef REG_SEQ_ERR_COUNT_EN
    for (int i = 0; i < 300; i++) push(4'd9, 16'h0000);
    wait_idle();
    chk("t6_saturated", 32'(err_count), 32'hFF);
    ip_reset = 1'b1;
    @(negedge Clk);
    chk("t6_cleared", 32'(err_count), 32'd0);
    ip_reset = 1'b0;
    @(negedge Clk);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
